// File: rtl/calc1_responder.sv
// rtl/calc1_responder.sv - four-port command responder with shared add/sub and shift units
//
// Ports:
//   c_clk        block clock, rising edge
//   reset        asynchronous active-high reset
//   req_cmd_in   per-port command (0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH, others invalid)
//   req_data_in  per-port operand bus, [0:31] with bit 31 the LSB
//   out_resp     per-port response (0 none, 1 success, 2 error)
//   out_data     per-port result, zero whenever out_resp is zero

module calc1_responder (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_cmd_in  [1:4],
  input  logic [0:31] req_data_in [1:4],
  output logic [1:0]  out_resp    [1:4],
  output logic [0:31] out_data    [1:4]
);

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_LSH = 4'd5;
  localparam logic [3:0] CMD_RSH = 4'd6;

  typedef enum logic [1:0] {IDLE, ARG2, WAIT} state_t;

  state_t      state_q [4];
  state_t      state_d [4];
  logic [3:0]  cmd_q   [4];
  logic [3:0]  cmd_d   [4];
  logic [31:0] op1_q   [4];
  logic [31:0] op1_d   [4];
  logic [31:0] op2_q   [4];
  logic [31:0] op2_d   [4];
  logic [1:0]  resp_d  [4];
  logic [31:0] data_d  [4];

  logic [1:0]  as_ptr_q, as_ptr_d;
  logic [1:0]  sh_ptr_q, sh_ptr_d;
  logic [3:0]  as_req, sh_req, as_gnt, sh_gnt;

  // Round-robin pick: scanning from ptr upward, the first requester wins.
  // Iterating offsets high-to-low lets the lowest offset overwrite last.
  function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [3:0] g;
    logic [1:0] idx;
    g = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + i[1:0];
      if (req[idx]) g = 4'b0001 << idx;
    end
    return g;
  endfunction

  // Pointer moves to the port after the granted one; unchanged when idle.
  function automatic logic [1:0] rr_advance(input logic [3:0] gnt, input logic [1:0] ptr);
    logic [1:0] nxt;
    nxt = ptr;
    for (int p = 0; p < 4; p++) begin
      if (gnt[p]) nxt = 2'(p + 1);
    end
    return nxt;
  endfunction

  // Returns {resp, data}. Anything not matched is an error response with zero data.
  function automatic logic [33:0] compute(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] sum;
    logic [33:0] r;
    r   = {2'd2, 32'd0};
    sum = {1'b0, a} + {1'b0, b};
    case (cmd)
      CMD_ADD: if (!sum[32]) r = {2'd1, sum[31:0]};
      CMD_SUB: if (a >= b)   r = {2'd1, a - b};
      CMD_LSH: r = {2'd1, a << b[4:0]};
      CMD_RSH: r = {2'd1, a >> b[4:0]};
      default: r = {2'd2, 32'd0};
    endcase
    return r;
  endfunction

  always_comb begin
    as_req = 4'b0000;
    sh_req = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      if (state_q[p] == WAIT) begin
        case (cmd_q[p])
          CMD_ADD, CMD_SUB: as_req[p] = 1'b1;
          CMD_LSH, CMD_RSH: sh_req[p] = 1'b1;
          default: ;
        endcase
      end
    end
    as_gnt   = rr_pick(as_req, as_ptr_q);
    sh_gnt   = rr_pick(sh_req, sh_ptr_q);
    as_ptr_d = rr_advance(as_gnt, as_ptr_q);
    sh_ptr_d = rr_advance(sh_gnt, sh_ptr_q);
  end

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      state_d[p] = state_q[p];
      cmd_d[p]   = cmd_q[p];
      op1_d[p]   = op1_q[p];
      op2_d[p]   = op2_q[p];
      resp_d[p]  = 2'd0;
      data_d[p]  = 32'd0;
      case (state_q[p])
        IDLE: begin
          if (req_cmd_in[p+1] != CMD_NOP) begin
            cmd_d[p]   = req_cmd_in[p+1];
            op1_d[p]   = req_data_in[p+1];
            state_d[p] = ARG2;
          end
        end
        ARG2: begin
          op2_d[p]   = req_data_in[p+1];
          state_d[p] = WAIT;
        end
        WAIT: begin
          // Invalid commands never request a unit and finish straight away.
          if (as_gnt[p] || sh_gnt[p] || (!as_req[p] && !sh_req[p])) begin
            {resp_d[p], data_d[p]} = compute(cmd_q[p], op1_q[p], op2_q[p]);
            state_d[p] = IDLE;
          end
        end
        default: state_d[p] = IDLE;
      endcase
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      as_ptr_q <= 2'd0;
      sh_ptr_q <= 2'd0;
      for (int p = 0; p < 4; p++) begin
        state_q[p]    <= IDLE;
        cmd_q[p]      <= CMD_NOP;
        op1_q[p]      <= 32'd0;
        op2_q[p]      <= 32'd0;
        out_resp[p+1] <= 2'd0;
        out_data[p+1] <= 32'd0;
      end
    end else begin
      as_ptr_q <= as_ptr_d;
      sh_ptr_q <= sh_ptr_d;
      for (int p = 0; p < 4; p++) begin
        state_q[p]    <= state_d[p];
        cmd_q[p]      <= cmd_d[p];
        op1_q[p]      <= op1_d[p];
        op2_q[p]      <= op2_d[p];
        out_resp[p+1] <= resp_d[p];
        out_data[p+1] <= data_d[p];
      end
    end
  end

endmodule

// File: tb/tb_calc1_responder.sv
// tb/tb_calc1_responder.sv - directed self-checking bench for calc1_responder

module tb_calc1_responder;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_cmd_in  [1:4];
  logic [0:31] req_data_in [1:4];
  logic [1:0]  out_resp    [1:4];
  logic [0:31] out_data    [1:4];

  int n_cmp = 0;
  int n_err = 0;

  calc1_responder dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data)
  );

  always #5 c_clk = ~c_clk;

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic idle_all();
    for (int p = 1; p <= 4; p++) begin
      req_cmd_in[p]  = 4'd0;
      req_data_in[p] = 32'd0;
    end
  endtask

  task automatic load1(input int p, input logic [3:0] c, input logic [31:0] a);
    req_cmd_in[p]  = c;
    req_data_in[p] = a;
  endtask

  task automatic load2(input int p, input logic [31:0] b);
    req_cmd_in[p]  = 4'd0;
    req_data_in[p] = b;
  endtask

  task automatic chk(input string tag, input int p, input logic [1:0] r, input logic [31:0] d);
    logic [31:0] got_d;
    got_d = out_data[p];
    n_cmp++;
    assert (out_resp[p] === r) else begin
      n_err++;
      $error("FAIL %s port%0d resp got %0d exp %0d", tag, p, out_resp[p], r);
    end
    n_cmp++;
    assert (got_d === d) else begin
      n_err++;
      $error("FAIL %s port%0d data got %h exp %h", tag, p, got_d, d);
    end
  endtask

  // Single-port operation from IDLE: checks the E2 response and the E3 clear.
  task automatic single(input string tag, input int p, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] r, input logic [31:0] d);
    load1(p, c, a);
    tick();
    load2(p, b);
    tick();
    idle_all();
    tick();
    chk(tag, p, r, d);
    tick();
    chk({tag, "_clr"}, p, 2'd0, 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  initial begin
    idle_all();
    tick();
    tick();
    reset = 1'b0;
    for (int p = 1; p <= 4; p++) chk("reset", p, 2'd0, 32'd0);

    single("add_basic", 1, 4'd1, 32'hFFFF0000, 32'h0000FFFF, 2'd1, 32'hFFFFFFFF);
    single("add_ovf",   2, 4'd1, 32'hFFFFFFFF, 32'h00000001, 2'd2, 32'h00000000);
    single("sub_unf",   2, 4'd2, 32'h00000000, 32'h00000001, 2'd2, 32'h00000000);
    single("sub_ok",    2, 4'd2, 32'h80000000, 32'h00000001, 2'd1, 32'h7FFFFFFF);
    single("sub_eq",    2, 4'd2, 32'h12345678, 32'h12345678, 2'd1, 32'h00000000);
    single("lsh31",     3, 4'd5, 32'h00000001, 32'h0000001F, 2'd1, 32'h80000000);
    single("rsh32",     3, 4'd6, 32'hFFFFFFFF, 32'h00000020, 2'd1, 32'hFFFFFFFF);
    single("rsh4",      3, 4'd6, 32'hF0000000, 32'hFFFFFFE4, 2'd1, 32'h0F000000);
    single("invalid",   4, 4'd3, 32'h00000005, 32'h00000007, 2'd2, 32'h00000000);

    // All four ports contend for the add/sub unit right after reset.
    pulse_reset();
    for (int p = 1; p <= 4; p++) load1(p, 4'd1, 32'h00000001);
    tick();
    for (int p = 1; p <= 4; p++) load2(p, 32'h0000FFFF);
    tick();
    idle_all();
    tick();
    chk("rr_e2_p1", 1, 2'd1, 32'h00010000);
    chk("rr_e2_p2", 2, 2'd0, 32'h00000000);
    tick();
    chk("rr_e3_p2", 2, 2'd1, 32'h00010000);
    chk("rr_e3_p1", 1, 2'd0, 32'h00000000);
    chk("rr_e3_p3", 3, 2'd0, 32'h00000000);
    tick();
    chk("rr_e4_p3", 3, 2'd1, 32'h00010000);
    chk("rr_e4_p4", 4, 2'd0, 32'h00000000);
    tick();
    chk("rr_e5_p4", 4, 2'd1, 32'h00010000);
    chk("rr_e5_p3", 3, 2'd0, 32'h00000000);

    // Pointer has wrapped back to port 1.
    load1(1, 4'd1, 32'h00000010);
    load1(3, 4'd1, 32'h00000100);
    tick();
    load2(1, 32'h00000001);
    load2(3, 32'h00000002);
    tick();
    idle_all();
    tick();
    chk("rr2_e2_p1", 1, 2'd1, 32'h00000011);
    chk("rr2_e2_p3", 3, 2'd0, 32'h00000000);
    tick();
    chk("rr2_e3_p3", 3, 2'd1, 32'h00000102);
    chk("rr2_e3_p1", 1, 2'd0, 32'h00000000);

    // Different units respond in the same cycle.
    load1(1, 4'd1, 32'h00000002);
    load1(4, 4'd6, 32'h00000080);
    tick();
    load2(1, 32'h00000003);
    load2(4, 32'h00000004);
    tick();
    idle_all();
    tick();
    chk("par_p1", 1, 2'd1, 32'h00000005);
    chk("par_p4", 4, 2'd1, 32'h00000008);

    // Commands during ARG2/WAIT are ignored: a second ADD mid-operation is dropped.
    tick();
    load1(2, 4'd1, 32'h00000003);
    tick();
    load1(2, 4'd1, 32'h00000050);
    tick();
    load1(2, 4'd1, 32'h00000060);
    tick();
    idle_all();
    chk("ign_e2", 2, 2'd1, 32'h00000053);
    tick();
    chk("ign_e3", 2, 2'd0, 32'h00000000);

    // Outputs clear asynchronously on reset.
    load1(1, 4'd1, 32'h00000001);
    tick();
    load2(1, 32'h00000001);
    tick();
    idle_all();
    tick();
    chk("pre_rst", 1, 2'd1, 32'h00000002);
    reset = 1'b1;
    #1;
    chk("async_rst", 1, 2'd0, 32'h00000000);
    #2;
    reset = 1'b0;
    tick();

    // Reset during WAIT discards the operation; next ADD starts right after.
    load1(1, 4'd1, 32'h00000100);
    tick();
    load2(1, 32'h00000200);
    tick();
    idle_all();
    reset = 1'b1;
    #2;
    load1(1, 4'd1, 32'h00000010);
    reset = 1'b0;
    tick();
    chk("disc_e0", 1, 2'd0, 32'h00000000);
    load2(1, 32'h00000020);
    tick();
    chk("disc_e1", 1, 2'd0, 32'h00000000);
    idle_all();
    tick();
    chk("after_rst", 1, 2'd1, 32'h00000030);
    tick();
    chk("after_rst_clr", 1, 2'd0, 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/calc1_responder.md
CALC1_RESPONDER -- requirements
Module: calc1_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, and no parameters.
REQ-002 c_clk  input  1  block clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 req_cmd_in[1:4]  input  4 each  per-port command: 0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH; all other codes are invalid.
REQ-005 req_data_in[1:4]  input  32 each ([0:31], bit 31 LSB)  operand 1 in the command cycle, operand 2 in the following cycle.
REQ-006 out_resp[1:4]  output  2 each  response code: 0 none, 1 success, 2 overflow/underflow/invalid command, 3 never driven.
REQ-007 out_data[1:4]  output  32 each  result; 0 whenever out_resp is 0.

Function
REQ-008 Each port SHALL run an independent FSM with states IDLE, ARG2, WAIT.
REQ-009 IDLE: a non-NOP cmd sampled at edge E0 SHALL latch cmd and operand 1 and move to ARG2; NOP keeps the port in IDLE.
REQ-010 ARG2: edge E1 SHALL latch operand 2 unconditionally and move to WAIT, whatever cmd is present.
REQ-011 Commands presented while a port is in ARG2 or WAIT SHALL be ignored; they are not queued.
REQ-012 There SHALL be one shared add/sub unit (ADD, SUB) and one shared shift unit (LSH, RSH), operating independently.
REQ-013 Each unit SHALL grant at most one WAIT port per cycle, using its own round-robin pointer.
REQ-014 On reset, each round-robin pointer SHALL be set to port 1.
REQ-015 After a grant, the pointer SHALL move to the port after the granted one (4 wraps to 1).
REQ-016 A port granted during its WAIT cycle SHALL register its result at the next edge, return to IDLE at that edge, and accept a new cmd from the edge after it.
REQ-017 A port with an invalid cmd SHALL not request a unit, and SHALL return resp 2 with data 0 at the edge after E1.
REQ-018 The uncontended response SHALL appear at edge E2 and be held for exactly one cycle; outputs return to 0/0 at E3.
REQ-019 An ungranted port SHALL stay in WAIT with its operands unchanged.
REQ-020 ADD SHALL be an unsigned 32-bit add; a carry out of bit 0 SHALL give resp 2 with data 0, otherwise resp 1 with the sum.
REQ-021 SUB SHALL be unsigned; operand 1 < operand 2 SHALL give resp 2 with data 0, otherwise resp 1 with the difference; equal operands give resp 1 with data 0.
REQ-022 The shift amount SHALL be operand 2 bits [27:31] (0-31); bits [0:26] are ignored.
REQ-023 LSH SHALL be a logical left shift of operand 1 and RSH a logical right shift, zero fill; shifts always give resp 1.
REQ-024 Ports granted by different units in the same cycle SHALL respond in the same cycle.

Reset
REQ-025 Reset asserted SHALL immediately force all FSMs to IDLE, clear all latched operands, set all out_resp to 0 and all out_data to 0, and set both pointers to port 1.
REQ-026 Reset asserted mid-operation (ARG2 or WAIT) SHALL discard the operation; no response is ever produced for it.
REQ-027 The first cmd SHALL be sampled at the first rising edge after reset deasserts.

Verification
REQ-028 After reset, port 1 ADD 0xFFFF0000 then 0x0000FFFF -> at E2, out_resp[1]=1 and out_data[1]=0xFFFFFFFF for one cycle; 0/0 at E3.
REQ-029 Port 2 ADD 0xFFFFFFFF+0x00000001 -> resp 2, data 0; SUB 0x00000000-0x00000001 -> resp 2, data 0; SUB 0x80000000-0x00000001 -> resp 1, data 0x7FFFFFFF.
REQ-030 ADD 0x00000001+0x0000FFFF issued on all four ports in the same cycle after reset -> resp 1, data 0x00010000 on port 1 at E2, then ports 2, 3, 4 at E3, E4, E5 in that order; then ADD on ports 1 and 3 together -> port 1 first, port 3 one cycle later.
REQ-031 Port 3 LSH 0x00000001 by 31 -> 0x80000000; RSH 0xFFFFFFFF by 32 -> 0xFFFFFFFF (amount 0); port 1 ADD and port 4 RSH issued together -> both respond at E2.
REQ-032 Port 4 cmd 3 -> resp 2, data 0 at E2, and no unit grant occurs.
REQ-033 Port 1 ADD with reset pulsed during WAIT -> no response; an ADD on the same port immediately after reset deasserts completes normally.
